// File: rtl/quiz_game_core_if.sv
// Quiz game core bus: question handshake, digit editing controls and game status.
interface quiz_game_core_if #(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned HP_INIT    = 3,
  parameter int unsigned ROUNDS     = 5,
  parameter int unsigned TIME_LIMIT = 1000
);
  localparam int unsigned SELW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned HPW  = $clog2(HP_INIT + 1);
  localparam int unsigned RW   = $clog2(ROUNDS + 1);
  localparam int unsigned TW   = $clog2(TIME_LIMIT + 1);
  localparam int unsigned AW   = DIGITS * 4;

  logic            ready;
  logic            q_valid;
  logic [AW-1:0]   q_data;
  logic            q_req;
  logic [SELW-1:0] sel;
  logic            inc;
  logic            clr;
  logic            submit;
  logic [AW-1:0]   answer;
  logic [2:0]      state;
  logic [HPW-1:0]  hp;
  logic [RW-1:0]   round;
  logic [TW-1:0]   timer;
  logic [1:0]      result;
  logic            win;
  logic            lose;

  // Player / question source side
  modport master (
    output ready, q_valid, q_data, sel, inc, clr, submit,
    input  q_req, answer, state, hp, round, timer, result, win, lose
  );

  // Game core side
  modport slave (
    input  ready, q_valid, q_data, sel, inc, clr, submit,
    output q_req, answer, state, hp, round, timer, result, win, lose
  );
endinterface

// File: rtl/quiz_game_core.sv
// Quiz game core: fetches BCD questions, lets the player edit digits under a
// time limit, scores answers and tracks lives and rounds to a win or loss.
module quiz_game_core #(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned HP_INIT     = 3,
  parameter int unsigned ROUNDS      = 5,
  parameter int unsigned TIME_LIMIT  = 1000,
  parameter int unsigned SHOW_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  quiz_game_core_if.slave bus
);
  localparam int unsigned HPW = $clog2(HP_INIT + 1);
  localparam int unsigned RW  = $clog2(ROUNDS + 1);
  localparam int unsigned TW  = $clog2(TIME_LIMIT + 1);
  localparam int unsigned AW  = DIGITS * 4;
  localparam int unsigned SCW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT_Q = 3'd2,
    S_INPUT  = 3'd3,
    S_CHECK  = 3'd4,
    S_SHOW   = 3'd5,
    S_WIN    = 3'd6,
    S_LOSE   = 3'd7
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  answer_q, answer_d;
  logic [AW-1:0]  quest_q, quest_d;
  logic [HPW-1:0] hp_q, hp_d;
  logic [RW-1:0]  round_q, round_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [1:0]     result_q, result_d;
  logic [SCW-1:0] show_q, show_d;
  logic           q_req_q, win_q, lose_q;

  // Next-state and datapath update for every game register
  always_comb begin
    state_d  = state_q;
    answer_d = answer_q;
    quest_d  = quest_q;
    hp_d     = hp_q;
    round_d  = round_q;
    timer_d  = timer_q;
    result_d = result_q;
    show_d   = show_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ready) begin
          hp_d     = HPW'(HP_INIT);
          round_d  = '0;
          result_d = 2'b00;
          state_d  = S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT_Q;
      S_WAIT_Q: begin
        if (bus.q_valid) begin
          quest_d  = bus.q_data;
          answer_d = '0;
          timer_d  = TW'(TIME_LIMIT);
          result_d = 2'b00;
          state_d  = S_INPUT;
        end
      end
      S_INPUT: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        if (bus.submit) begin
          state_d = S_CHECK;
        end else begin
          if (bus.clr) begin
            answer_d = '0;
          end else if (bus.inc) begin
            // An out-of-range SEL matches no digit and is dropped here
            for (int unsigned i = 0; i < DIGITS; i++) begin
              if (SELW_MATCH(i)) begin
                answer_d[i*4 +: 4] = (answer_q[i*4 +: 4] == 4'd9) ? 4'd0
                                   : answer_q[i*4 +: 4] + 4'd1;
              end
            end
          end
          if (timer_q == TW'(1)) begin
            result_d = 2'b11;
            hp_d     = (hp_q != '0) ? hp_q - HPW'(1) : hp_q;
            show_d   = '0;
            state_d  = S_SHOW;
          end
        end
      end
      S_CHECK: begin
        if (answer_q == quest_q) begin
          result_d = 2'b01;
          round_d  = (round_q != RW'(ROUNDS)) ? round_q + RW'(1) : round_q;
        end else begin
          result_d = 2'b10;
          hp_d     = (hp_q != '0) ? hp_q - HPW'(1) : hp_q;
        end
        show_d  = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (show_q == SCW'(SHOW_CYCLES - 1)) begin
          if (hp_q == '0)                 state_d = S_LOSE;
          else if (round_q == RW'(ROUNDS)) state_d = S_WIN;
          else                            state_d = S_REQ;
        end else begin
          show_d = show_q + SCW'(1);
        end
      end
      S_WIN, S_LOSE: begin
        if (bus.ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Digit index compare kept at the select width so no bits are dropped
  function automatic logic SELW_MATCH(input int unsigned idx);
    return ($bits(bus.sel))'(idx) == bus.sel;
  endfunction

  // State and output registers; reset wins over everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      answer_q <= '0;
      quest_q  <= '0;
      hp_q     <= HPW'(HP_INIT);
      round_q  <= '0;
      timer_q  <= '0;
      result_q <= 2'b00;
      show_q   <= '0;
      q_req_q  <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      answer_q <= answer_d;
      quest_q  <= quest_d;
      hp_q     <= hp_d;
      round_q  <= round_d;
      timer_q  <= timer_d;
      result_q <= result_d;
      show_q   <= show_d;
      q_req_q  <= (state_d == S_REQ);
      win_q    <= (state_d == S_WIN);
      lose_q   <= (state_d == S_LOSE);
    end
  end

  assign bus.q_req  = q_req_q;
  assign bus.answer = answer_q;
  assign bus.state  = state_q;
  assign bus.hp     = hp_q;
  assign bus.round  = round_q;
  assign bus.timer  = timer_q;
  assign bus.result = result_q;
  assign bus.win    = win_q;
  assign bus.lose   = lose_q;
endmodule
